// File: rtl/core_mem_stage_if.sv
// Data bus bundle between core_mem_stage and memory.
// Master drives the request side, slave returns ack/rdata.
interface core_mem_stage_if #(
   parameter int DATA_W = 32
);
   logic              dbus_req;
   logic              dbus_we;
   logic [DATA_W-1:0] dbus_addr;
   logic [DATA_W-1:0] dbus_wdata;
   logic              dbus_ack;
   logic [DATA_W-1:0] dbus_rdata;

   modport master (
      output dbus_req,
      output dbus_we,
      output dbus_addr,
      output dbus_wdata,
      input  dbus_ack,
      input  dbus_rdata
   );

   modport slave (
      input  dbus_req,
      input  dbus_we,
      input  dbus_addr,
      input  dbus_wdata,
      output dbus_ack,
      output dbus_rdata
   );
endinterface

// File: rtl/core_mem_stage.sv
// Memory/writeback stage after the ALU: flags, word load/store, writeback.
// Optional macro I2D_MEM_TIMEOUT_EN aborts a bus cycle after MEM_TIMEOUT.
module core_mem_stage #(
   parameter int DATA_W      = 32,
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_is_load,
   input  logic              ex_is_store,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_rd_we,
   input  logic              ex_flag_we,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [2:0]        ex_flag,
   output logic [2:0]        flag_q,
   output logic              mem_stall,
   core_mem_stage_if.master  dbus,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_err
);

   typedef enum logic {IDLE, BUS} state_t;

   state_t            state, state_n;
   logic              accept;
   logic              is_mem;
   logic              misal;
   logic              go_bus;
   logic              abort;
   logic [REG_AW-1:0] rd_q;
   logic              rd_we_q;

   assign mem_stall = (state != IDLE);
   assign accept    = (state == IDLE) && ex_valid;
   assign is_mem    = ex_is_load | ex_is_store;
   assign misal     = |ex_alu_result[1:0];
   assign go_bus    = accept && is_mem && !misal;

`ifdef I2D_MEM_TIMEOUT_EN
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   logic [CW-1:0] cnt;

   assign abort = (state == BUS) && !dbus.dbus_ack &&
                  (cnt == CW'(MEM_TIMEOUT - 1));

   // Bus-cycle counter; cleared on BUS entry, counts un-acked cycles.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (go_bus)
         cnt <= '0;
      else if (state == BUS && !dbus.dbus_ack)
         cnt <= cnt + 1'b1;
   end
`else
   assign abort = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next-state: enter BUS on aligned access, leave on ack or abort.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (go_bus) state_n = BUS;
         BUS:  if (dbus.dbus_ack || abort) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Flags, bus request registers and writeback outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q          <= '0;
         dbus.dbus_req   <= 1'b0;
         dbus.dbus_we    <= 1'b0;
         dbus.dbus_addr  <= '0;
         dbus.dbus_wdata <= '0;
         rd_q            <= '0;
         rd_we_q         <= 1'b0;
         wb_valid        <= 1'b0;
         wb_we           <= 1'b0;
         wb_rd           <= '0;
         wb_data         <= '0;
         mem_err         <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         wb_we    <= 1'b0;
         mem_err  <= 1'b0;
         if (accept) begin
            if (ex_flag_we)
               flag_q <= ex_flag;
            if (!is_mem) begin
               wb_valid <= 1'b1;
               wb_we    <= ex_rd_we;
               wb_rd    <= ex_rd;
               wb_data  <= ex_alu_result;
            end else if (misal) begin
               mem_err <= 1'b1;
            end else begin
               dbus.dbus_req   <= 1'b1;
               dbus.dbus_we    <= ex_is_store;
               dbus.dbus_addr  <= ex_alu_result;
               dbus.dbus_wdata <= ex_store_data;
               rd_q            <= ex_rd;
               rd_we_q         <= ex_rd_we;
            end
         end
         if (state == BUS) begin
            if (dbus.dbus_ack) begin
               dbus.dbus_req <= 1'b0;
               wb_valid      <= 1'b1;
               wb_rd         <= rd_q;
               if (dbus.dbus_we) begin
                  wb_we   <= 1'b0;
                  wb_data <= '0;
               end else begin
                  wb_we   <= rd_we_q;
                  wb_data <= dbus.dbus_rdata;
               end
            end else if (abort) begin
               dbus.dbus_req <= 1'b0;
               mem_err       <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_core_mem_stage.sv
// Directed self-checking bench for core_mem_stage.
// Timeout steps run only when I2D_MEM_TIMEOUT_EN is defined.
module tb_core_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_is_load, ex_is_store;
   logic [4:0]  ex_rd;
   logic        ex_rd_we, ex_flag_we;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [2:0]  ex_flag;
   logic [2:0]  flag_q;
   logic        mem_stall;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mem_err;

   int errors = 0;
   int checks = 0;

   core_mem_stage_if #(.DATA_W(32)) bus ();

   core_mem_stage #(
      .DATA_W(32), .REG_AW(5), .MEM_TIMEOUT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load),
      .ex_is_store(ex_is_store), .ex_rd(ex_rd),
      .ex_rd_we(ex_rd_we), .ex_flag_we(ex_flag_we),
      .ex_alu_result(ex_alu_result),
      .ex_store_data(ex_store_data), .ex_flag(ex_flag),
      .flag_q(flag_q), .mem_stall(mem_stall),
      .dbus(bus.master),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      ex_valid      = 1'b0;
      ex_is_load    = 1'b0;
      ex_is_store   = 1'b0;
      ex_rd         = '0;
      ex_rd_we      = 1'b0;
      ex_flag_we    = 1'b0;
      ex_alu_result = '0;
      ex_store_data = '0;
      ex_flag       = '0;
   endtask

   task automatic op(input logic ld, input logic st,
                     input logic [4:0] rd, input logic rdwe,
                     input logic fwe, input logic [2:0] fl,
                     input logic [31:0] res, input logic [31:0] sd);
      ex_valid      = 1'b1;
      ex_is_load    = ld;
      ex_is_store   = st;
      ex_rd         = rd;
      ex_rd_we      = rdwe;
      ex_flag_we    = fwe;
      ex_flag       = fl;
      ex_alu_result = res;
      ex_store_data = sd;
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      bus.dbus_ack   = 1'b0;
      bus.dbus_rdata = '0;
      step();
      step();
      check("rst_flag", 32'(flag_q), 0);
      check("rst_stall", 32'(mem_stall), 0);
      check("rst_req", 32'(bus.dbus_req), 0);
      check("rst_we", 32'(bus.dbus_we), 0);
      check("rst_addr", bus.dbus_addr, 0);
      check("rst_wdata", bus.dbus_wdata, 0);
      check("rst_wbv", 32'(wb_valid), 0);
      check("rst_wbwe", 32'(wb_we), 0);
      check("rst_wbrd", 32'(wb_rd), 0);
      check("rst_wbdata", wb_data, 0);
      check("rst_err", 32'(mem_err), 0);
      rst = 1'b0;
      step();

      // ADD
      op(0, 0, 5'd3, 1, 1, 3'b101, 32'h10, 0);
      step();
      check("add_wbv", 32'(wb_valid), 1);
      check("add_wbwe", 32'(wb_we), 1);
      check("add_wbrd", 32'(wb_rd), 3);
      check("add_wbdata", wb_data, 32'h10);
      check("add_flag", 32'(flag_q), 3'b101);
      check("add_stall", 32'(mem_stall), 0);
      idle_in();
      step();
      check("add_wbv_drop", 32'(wb_valid), 0);

      // Load 0x100, ack in third BUS cycle
      op(1, 0, 5'd5, 1, 0, 3'b000, 32'h100, 0);
      step();
      check("ld_req1", 32'(bus.dbus_req), 1);
      check("ld_addr1", bus.dbus_addr, 32'h100);
      check("ld_we1", 32'(bus.dbus_we), 0);
      check("ld_stall1", 32'(mem_stall), 1);
      check("ld_wbv1", 32'(wb_valid), 0);
      step();
      check("ld_req2", 32'(bus.dbus_req), 1);
      check("ld_addr2", bus.dbus_addr, 32'h100);
      check("ld_stall2", 32'(mem_stall), 1);
      step();
      check("ld_req3", 32'(bus.dbus_req), 1);
      check("ld_addr3", bus.dbus_addr, 32'h100);
      check("ld_stall3", 32'(mem_stall), 1);
      bus.dbus_ack   = 1'b1;
      bus.dbus_rdata = 32'hDEADBEEF;
      step();
      bus.dbus_ack   = 1'b0;
      bus.dbus_rdata = '0;
      idle_in();
      check("ld_req_drop", 32'(bus.dbus_req), 0);
      check("ld_stall_drop", 32'(mem_stall), 0);
      check("ld_wbv", 32'(wb_valid), 1);
      check("ld_wbwe", 32'(wb_we), 1);
      check("ld_wbrd", 32'(wb_rd), 5);
      check("ld_wbdata", wb_data, 32'hDEADBEEF);
      step();

      // Store 0x200, then ADD presented in the store writeback cycle
      op(0, 1, 5'd2, 0, 0, 3'b000, 32'h200, 32'h55AA);
      step();
      check("st_req", 32'(bus.dbus_req), 1);
      check("st_we", 32'(bus.dbus_we), 1);
      check("st_addr", bus.dbus_addr, 32'h200);
      check("st_wdata", bus.dbus_wdata, 32'h55AA);
      bus.dbus_ack = 1'b1;
      step();
      bus.dbus_ack = 1'b0;
      check("st_req_drop", 32'(bus.dbus_req), 0);
      check("st_wbv", 32'(wb_valid), 1);
      check("st_wbwe", 32'(wb_we), 0);
      check("st_wbrd", 32'(wb_rd), 2);
      check("st_wbdata", wb_data, 0);
      check("st_flag", 32'(flag_q), 3'b101);
      op(0, 0, 5'd7, 1, 1, 3'b010, 32'h44, 0);
      step();
      idle_in();
      check("add2_wbv", 32'(wb_valid), 1);
      check("add2_wbrd", 32'(wb_rd), 7);
      check("add2_wbdata", wb_data, 32'h44);
      check("add2_flag", 32'(flag_q), 3'b010);
      check("add2_req", 32'(bus.dbus_req), 0);
      step();

      // Misaligned load
      op(1, 0, 5'd9, 1, 0, 3'b111, 32'h102, 0);
      step();
      idle_in();
      check("mis_req", 32'(bus.dbus_req), 0);
      check("mis_err", 32'(mem_err), 1);
      check("mis_wbv", 32'(wb_valid), 0);
      check("mis_flag", 32'(flag_q), 3'b010);
      check("mis_stall", 32'(mem_stall), 0);
      step();
      check("mis_err_drop", 32'(mem_err), 0);

      // Stray ack while idle
      bus.dbus_ack = 1'b1;
      step();
      bus.dbus_ack = 1'b0;
      check("idle_ack_wbv", 32'(wb_valid), 0);

      // Load+store both set behaves as store
      op(1, 1, 5'd4, 1, 0, 3'b000, 32'h204, 32'h1234);
      step();
      idle_in();
      check("ls_we", 32'(bus.dbus_we), 1);
      bus.dbus_ack   = 1'b1;
      bus.dbus_rdata = 32'hFFFF0000;
      step();
      bus.dbus_ack   = 1'b0;
      bus.dbus_rdata = '0;
      check("ls_wbwe", 32'(wb_we), 0);
      check("ls_wbdata", wb_data, 0);
      step();

      // Reset mid-BUS
      op(1, 0, 5'd6, 1, 0, 3'b000, 32'h300, 0);
      step();
      idle_in();
      check("rb_req", 32'(bus.dbus_req), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rb_req0", 32'(bus.dbus_req), 0);
      check("rb_stall", 32'(mem_stall), 0);
      check("rb_addr", bus.dbus_addr, 0);
      check("rb_flag", 32'(flag_q), 0);
      check("rb_wbv", 32'(wb_valid), 0);
      bus.dbus_ack   = 1'b1;
      bus.dbus_rdata = 32'hCAFE;
      step();
      bus.dbus_ack   = 1'b0;
      check("rb_late_wbv", 32'(wb_valid), 0);
      check("rb_late_data", wb_data, 0);

`ifdef I2D_MEM_TIMEOUT_EN
      // No ack: abort after 4 BUS cycles
      op(1, 0, 5'd8, 1, 0, 3'b000, 32'h400, 0);
      step();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("to_req%0d", i), 32'(bus.dbus_req), 1);
         check($sformatf("to_err%0d", i), 32'(mem_err), 0);
         step();
      end
      check("to_req_drop", 32'(bus.dbus_req), 0);
      check("to_err", 32'(mem_err), 1);
      check("to_wbv", 32'(wb_valid), 0);
      check("to_stall", 32'(mem_stall), 0);
      step();
      check("to_err_drop", 32'(mem_err), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/core_mem_stage.md
Name: core_mem_stage

Overview:
Pipeline stage directly downstream of the core ALU.
- Consumes the ALU result and the updated flags.
- Owns the architectural flag register, which feeds the ALU flag input.
- Performs word load/store over a req/ack data bus.
- Drives the register-file writeback port and the stall (halt) signal back to the execute stage.

Parameters:
DATA_W, 32, data/address width
REG_AW, 5, register index width
MEM_TIMEOUT, 64, max BUS cycles before abort (used only with optional feature)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
ex_valid  in  1  execute stage presents a valid instruction
ex_is_load  in  1  instruction is a word load
ex_is_store  in  1  instruction is a word store
ex_rd  in  REG_AW  destination register index
ex_rd_we  in  1  instruction writes ex_rd
ex_flag_we  in  1  instruction updates flags
ex_alu_result  in  DATA_W  ALU result (effective address for load/store)
ex_store_data  in  DATA_W  store data
ex_flag  in  3  {cf,of,zf} produced by ALU
flag_q  out  3  architectural flags {cf,of,zf}, to ALU flag input
mem_stall  out  1  upstream must hold; drives ALU ex_halt
dbus_req  out  1  bus request
dbus_we  out  1  1 = write
dbus_addr  out  DATA_W  word address
dbus_wdata  out  DATA_W  write data
dbus_ack  in  1  bus completion; 1-cycle pulse
dbus_rdata  in  DATA_W  read data, valid with dbus_ack
wb_valid  out  1  instruction retired this cycle
wb_we  out  1  register-file write enable
wb_rd  out  REG_AW  writeback index
wb_data  out  DATA_W  writeback data
mem_err  out  1  1-cycle pulse: misaligned access (or timeout)

Behaviour:
- Reset:
  - state=IDLE.
  - flag_q=0, mem_stall=0.
  - dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0.
  - wb_valid=0, wb_we=0, wb_rd=0, wb_data=0.
  - mem_err=0.
  - Reset mid-BUS drops dbus_req the next cycle; no writeback; a late ack is ignored in IDLE.
- mem_stall = (state != IDLE), combinational from the state register.
- Acceptance: rising edge with state==IDLE && ex_valid. Upstream holds inputs stable while mem_stall=1.
- Flags: on acceptance with ex_flag_we, flag_q <= ex_flag. Never updated while stalled or when ex_valid=0.
- wb_valid, wb_we and mem_err default to 0 every cycle unless set below.
- States and transitions:
  - IDLE, non-memory accept:
    - Next cycle: wb_valid=1, wb_we=ex_rd_we, wb_rd=ex_rd, wb_data=ex_alu_result.
    - Stay IDLE. Throughput 1/cycle, latency 1.
  - IDLE, load/store accept, ex_alu_result[1:0]!=0:
    - No bus cycle, no writeback.
    - mem_err=1 next cycle; stay IDLE.
  - IDLE, load/store accept, aligned:
    - Register dbus_addr=ex_alu_result, dbus_we=ex_is_store, dbus_wdata=ex_store_data, rd/rd_we.
    - dbus_req=1 next cycle; go BUS.
  - BUS:
    - dbus_req held 1 with stable addr/we/wdata until dbus_ack.
    - Ack at the same edge as req rise is impossible: req rises only on entry to BUS.
  - BUS with dbus_ack:
    - dbus_req=0 next cycle; go IDLE.
    - Next cycle: wb_valid=1, wb_rd=latched rd.
    - Load: wb_we=latched rd_we, wb_data=dbus_rdata.
    - Store: wb_we=0, wb_data=0.
- Minimum load/store occupancy: 2 cycles (accept + 1 BUS cycle). Next instruction is accepted in the cycle wb_valid is high.
- ex_is_load && ex_is_store both set: treated as store.
- Load writing a register is never forwarded here; hazard handling is upstream.

Optional Feature:
Macro I2D_MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on BUS entry and increments each BUS cycle without ack.
  - When it reaches MEM_TIMEOUT: dbus_req=0 next cycle, go IDLE, mem_err=1 pulse, no writeback.
  - Ack in the same cycle as the timeout wins: normal completion.
- Undefined: no counter; BUS waits indefinitely.

Test Plan:
- Reset, then sample outputs -> all outputs 0, flag_q=3'b000, mem_stall=0.
- ADD accepted: alu_result=0x10, rd=3, rd_we=1, flag_we=1, ex_flag=3'b101 -> next cycle wb_valid=1, wb_rd=3, wb_data=0x10; flag_q=3'b101; mem_stall never 1.
- Load from 0x100, ack after 3 BUS cycles with rdata=0xDEADBEEF -> dbus_req high 3 cycles, addr stable 0x100, mem_stall high 3 cycles; cycle after ack: wb_we=1, wb_data=0xDEADBEEF.
- Store to 0x200, wdata=0x55AA, back-to-back ADD held upstream -> single write with dbus_we=1; store wb_valid=1 with wb_we=0; ADD wb_valid the following cycle; ADD flags not applied before its acceptance.
- Load with address 0x102 -> no dbus_req, mem_err pulses 1 cycle, wb_valid=0, flag_q unchanged.
- With I2D_MEM_TIMEOUT_EN, MEM_TIMEOUT=4, no ack -> dbus_req drops after 4 BUS cycles, mem_err pulse, no writeback. Also assert rst mid-BUS -> next cycle IDLE with all outputs 0.
